// File: rtl/lfsr_bank.sv
// Multi-channel XNOR-feedback LFSR bank with seed loading, valid/ready output,
// lock-up substitution and per-channel return-to-seed detection.
module lfsr_bank #(
    parameter int               WIDTH  = 16,
    parameter int               NUM_CH = 4,
    parameter logic [WIDTH-1:0] TAPS   = 16'hD008,
    parameter int               CNT_W  = 32
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      load,
    input  logic [NUM_CH*WIDTH-1:0]   seed,
    input  logic                      out_ready,
    output logic                      out_valid,
    output logic [NUM_CH*WIDTH-1:0]   out_data,
    output logic [CNT_W-1:0]          step_cnt,
    output logic [NUM_CH-1:0]         lockup_fix,
    output logic [NUM_CH-1:0]         period_hit
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] lfsr_q   [NUM_CH];
    logic [WIDTH-1:0] seed_q   [NUM_CH];
    logic [WIDTH-1:0] lfsr_nxt [NUM_CH];
    logic             advance;

    function automatic logic [WIDTH-1:0] lfsr_step(input logic [WIDTH-1:0] s);
        return {s[WIDTH-2:0], ~(^(s & TAPS))};
    endfunction

    // All-ones is the only state XNOR feedback can never leave.
    function automatic logic [WIDTH-1:0] lockup_sub(input logic [WIDTH-1:0] s);
        return (&s) ? '0 : s;
    endfunction

    always_comb begin
        state_d = state_q;
        if (load)
            state_d = RUN;
    end

    assign advance   = (state_q == RUN) && out_ready && !load;
    assign out_valid = (state_q == RUN);

    always_comb begin
        for (int c = 0; c < NUM_CH; c++)
            lfsr_nxt[c] = lfsr_step(lfsr_q[c]);
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_pack
        assign out_data[g*WIDTH +: WIDTH] = lfsr_q[g];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            step_cnt   <= '0;
            lockup_fix <= '0;
            period_hit <= '0;
            for (int c = 0; c < NUM_CH; c++) begin
                lfsr_q[c] <= '0;
                seed_q[c] <= '0;
            end
        end else begin
            state_q <= state_d;
            if (load) begin
                step_cnt   <= '0;
                period_hit <= '0;
                for (int c = 0; c < NUM_CH; c++) begin
                    lfsr_q[c]     <= lockup_sub(seed[c*WIDTH +: WIDTH]);
                    seed_q[c]     <= lockup_sub(seed[c*WIDTH +: WIDTH]);
                    lockup_fix[c] <= &seed[c*WIDTH +: WIDTH];
                end
            end else if (advance) begin
                step_cnt <= step_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
                for (int c = 0; c < NUM_CH; c++) begin
                    lfsr_q[c] <= lfsr_nxt[c];
                    if (lfsr_nxt[c] == seed_q[c])
                        period_hit[c] <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_lfsr_bank.sv
// Randomised self-checking bench for lfsr_bank against a parity-counting
// reference model of the channel sequences.
module tb_lfsr_bank;

    localparam int          W    = 16;
    localparam int          N    = 4;
    localparam logic [15:0] TAPS = 16'hD008;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            load = 1'b0;
    logic [N*W-1:0]  seed = '0;
    logic            out_ready = 1'b0;
    logic            out_valid;
    logic [N*W-1:0]  out_data;
    logic [31:0]     step_cnt;
    logic [N-1:0]    lockup_fix;
    logic [N-1:0]    period_hit;

    int n_cmp = 0;
    int n_bad = 0;

    logic [15:0] m_state [N];
    logic [15:0] m_seed  [N];
    logic [31:0] m_cnt;
    logic [N-1:0] m_fix;
    logic [N-1:0] m_hit;
    logic        m_run;

    lfsr_bank #(.WIDTH(W), .NUM_CH(N), .TAPS(TAPS), .CNT_W(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .load       (load),
        .seed       (seed),
        .out_ready  (out_ready),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .step_cnt   (step_cnt),
        .lockup_fix (lockup_fix),
        .period_hit (period_hit)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Feedback is 1 when an even number of tapped bits are set.
    function automatic logic [15:0] ref_next(input logic [15:0] s);
        int ones = 0;
        for (int i = 0; i < W; i++)
            if (s[i] && TAPS[i]) ones++;
        return ((s << 1) | ((ones % 2 == 0) ? 16'd1 : 16'd0)) & 16'hFFFF;
    endfunction

    function automatic logic [63:0] ref_pack();
        logic [63:0] p = '0;
        for (int c = 0; c < N; c++)
            p = p | (64'(m_state[c]) << (c * W));
        return p;
    endfunction

    task automatic model_reset();
        for (int c = 0; c < N; c++) begin
            m_state[c] = '0;
            m_seed[c]  = '0;
        end
        m_cnt = '0; m_fix = '0; m_hit = '0; m_run = 1'b0;
    endtask

    task automatic check_all(input string tag);
        check({tag, ".valid"}, 64'(out_valid), 64'(m_run));
        check({tag, ".data"}, out_data, ref_pack());
        check({tag, ".cnt"}, 64'(step_cnt), 64'(m_cnt));
        check({tag, ".fix"}, 64'(lockup_fix), 64'(m_fix));
        check({tag, ".hit"}, 64'(period_hit), 64'(m_hit));
    endtask

    task automatic tick(input logic ld, input logic [N*W-1:0] sd, input logic rdy, input string tag);
        logic [15:0] s;
        @(negedge clk);
        load = ld; seed = sd; out_ready = rdy;
        @(posedge clk);
        if (ld) begin
            for (int c = 0; c < N; c++) begin
                s = sd[c*W +: W];
                m_fix[c]   = (s == 16'hFFFF);
                m_state[c] = m_fix[c] ? 16'h0000 : s;
                m_seed[c]  = m_state[c];
            end
            m_cnt = 0; m_hit = '0; m_run = 1'b1;
        end else if (m_run && rdy) begin
            for (int c = 0; c < N; c++) begin
                m_state[c] = ref_next(m_state[c]);
                if (m_state[c] == m_seed[c]) m_hit[c] = 1'b1;
            end
            m_cnt = m_cnt + 1;
        end
        #1;
        check_all(tag);
    endtask

    initial begin
        logic [63:0] sd;
        model_reset();
        #2;
        check_all("rst_hold");
        @(negedge clk);
        reset = 1'b0;

        // Idle with out_ready high
        for (int i = 0; i < 10; i++) tick(1'b0, '0, 1'b1, "idle");
        check("idle_data", out_data, 64'h0);

        // Channel 0 known sequence
        tick(1'b1, {16'h1111, 16'h2222, 16'h3333, 16'h0001}, 1'b0, "ld_seq");
        check("seq0", 64'(out_data[15:0]), 64'h0001);
        tick(1'b0, '0, 1'b1, "seq"); check("seq1", 64'(out_data[15:0]), 64'h0003);
        tick(1'b0, '0, 1'b1, "seq"); check("seq2", 64'(out_data[15:0]), 64'h0007);
        tick(1'b0, '0, 1'b1, "seq"); check("seq3", 64'(out_data[15:0]), 64'h000F);
        tick(1'b0, '0, 1'b1, "seq"); check("seq4", 64'(out_data[15:0]), 64'h001E);
        check("seq_cnt", 64'(step_cnt), 64'd4);

        // Lock-up substitution on channel 2
        tick(1'b1, {16'h1234, 16'hFFFF, 16'h1234, 16'h1234}, 1'b0, "ld_lock");
        check("lock_ch2", 64'(out_data[47:32]), 64'h0000);
        check("lock_fix", 64'(lockup_fix), 64'b0100);
        tick(1'b0, '0, 1'b1, "lock_adv");
        check("lock_ch2_adv", 64'(out_data[47:32]), 64'h0001);
        tick(1'b1, {16'h1234, 16'h0001, 16'h1234, 16'h1234}, 1'b0, "ld_unlock");
        check("unlock_fix", 64'(lockup_fix), 64'b0000);

        // Random backpressure with occasional reloads
        for (int i = 0; i < 400; i++) begin
            sd = {$urandom, $urandom};
            if ($urandom_range(0, 3) == 0) sd[16*$urandom_range(0, 3) +: 16] = 16'hFFFF;
            tick(($urandom_range(0, 15) == 0), sd, 1'($urandom_range(0, 1)), "rand");
        end

        // Load wins over a simultaneous accept
        tick(1'b1, 64'h0F0F_1357_2468_ACE1, 1'b1, "prio");
        check("prio_data", out_data, 64'h0F0F_1357_2468_ACE1);
        check("prio_cnt", 64'(step_cnt), 64'd0);

        // Full period from 0xACE1 on every channel
        tick(1'b1, {4{16'hACE1}}, 1'b0, "ld_per");
        for (int i = 0; i < 65534; i++) tick(1'b0, '0, 1'b1, "per");
        check("per_before", 64'(period_hit), 64'h0);
        tick(1'b0, '0, 1'b1, "per_last");
        check("per_cnt", 64'(step_cnt), 64'h0000FFFF);
        check("per_hit", 64'(period_hit), 64'b1111);

        // Asynchronous reset mid-run
        tick(1'b1, 64'hDEAD_BEEF_0123_4567, 1'b0, "ld_ar");
        for (int i = 0; i < 100; i++) tick(1'b0, '0, 1'b1, "ar_run");
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        check_all("ar_now");
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 5; i++) tick(1'b0, '0, 1'b1, "ar_idle");
        tick(1'b1, 64'h0001_0002_0003_0004, 1'b1, "ar_reload");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/lfsr_bank.md
# lfsr_bank

Parametrised multi-channel pseudo-random generator: NUM_CH independent WIDTH-bit XNOR-feedback shift registers with a programmable tap mask, a seed-load interface, a valid/ready output handshake, lock-up protection and per-channel period detection. It is the general successor to the fixed 16-bit four-channel generator and feeds the pattern/test-vector consumers of the design.

## Interface
- WIDTH, 16: bits per channel (≥ 3).
- NUM_CH, 4: number of channels.
- TAPS, 16'hD008: WIDTH-bit tap mask (bit i set ⇒ state[i] feeds back). The default selects bits 15, 14, 12 and 3, which is maximal length (period 65535).
- CNT_W, 32: width of the accepted-word counter.
- clk  input  1  clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-high; internal state is retimed to the idle condition described below.
- load  input  1  seed-load strobe, one-cycle sample.
- seed  input  NUM_CH*WIDTH  per-channel seeds; channel c occupies [c*WIDTH +: WIDTH].
- out_ready  input  1  consumer accepts out_data this cycle.
- out_valid  output  1  out_data holds a valid word.
- out_data  output  NUM_CH*WIDTH  current channel states, same packing as seed.
- step_cnt  output  CNT_W  number of accepted words since the last load.
- lockup_fix  output  NUM_CH  sticky: channel seed was the lock-up value and was substituted.
- period_hit  output  NUM_CH  sticky: channel has returned to its loaded seed.

## Operation
- Feedback per channel is fb = ~(XOR over i of state[i] & TAPS[i]). Advance is state ← {state[WIDTH-2:0], fb}.
- The lock-up state for XNOR feedback is all-ones. All-zeros is a legal state.
- FSM states:
  - IDLE: entered on reset; out_valid = 0; load moves to RUN.
  - RUN: out_valid = 1; stays in RUN, and a load in RUN reloads.
  - There is no other exit from RUN except reset.
- Load, in any state:
  - Each channel is set to its seed slice, or to all-zeros if the slice is all-ones. In the substituted case lockup_fix[c] is set; otherwise it is cleared.
  - The effective seed is stored per channel.
  - step_cnt ← 0 and period_hit ← 0.
- Advance occurs when state is RUN and out_valid & out_ready & ~load:
  - All channels step together.
  - step_cnt increments modulo 2^CNT_W.
  - For each channel whose next state equals its stored seed, period_hit[c] is set and stays set until the next load or reset.
- Simultaneous load and out_ready: load wins and no advance occurs. The word presented that cycle is considered not consumed.
- out_ready low in RUN: state holds and out_data stays stable.
- Reset values: out_valid 0, out_data 0, step_cnt 0, lockup_fix 0, period_hit 0, stored seeds 0, FSM IDLE.
- Reset mid-operation discards everything; a new load is required.
- In IDLE, out_ready is ignored.

## Timing
- load sampled at edge N ⇒ out_data = effective seed and out_valid = 1 from N+1. lockup_fix is valid from N+1.
- Handshake at edge N ⇒ the next state appears on out_data at N+1, so throughput is one word per cycle with out_ready held high.
- step_cnt and period_hit update on the same edge as the advance that causes them.
- All outputs are registered; there is no combinational path from inputs to outputs.
- Asserting reset clears outputs immediately (asynchronous). The first load is taken on the first edge after reset deasserts.

## Test plan
- Reset then idle: out_ready = 1, no load, 10 cycles → out_valid = 0, out_data = 0, step_cnt = 0.
- Channel 0 sequence: load seed 0x0001, out_ready = 1 → channel 0 out_data over successive cycles is 0x0001, 0x0003, 0x0007, 0x000F, 0x001E; step_cnt = 4 after the fourth accept.
- Lock-up substitution: load with channel 2 seed 0xFFFF and the others 0x1234 → channel 2 reads 0x0000 and lockup_fix = 4'b0100. One accept later channel 2 = 0x0001. A later load of 0x0001 clears lockup_fix[2].
- Backpressure and priority:
  - Toggle out_ready randomly → out_data changes only after cycles with out_ready = 1.
  - Assert load with out_ready = 1 → out_data = new seed next cycle, step_cnt = 0, no extra advance.
- Period detection: load all channels with 0xACE1, out_ready = 1 → period_hit = 4'b1111 exactly at step_cnt = 65535 (0x0000FFFF), and not before.
- Asynchronous reset mid-run: assert reset between edges after 100 accepts → all outputs are 0 before the next edge. After release, out_valid stays 0 until a load.
